multdiv_sequencer: RTL
======================

# multdiv_sequencer

Multi-cycle sequencer for signed 32-bit multiply and divide in the 5-stage pipeline. The decoder flags an ALU-class instruction whose ALU opcode selects mul or div; execute then pulses a start into this block. The block stalls the pipeline while it iterates and returns the result, the destination-register tag and an rstatus exception code for writeback.

## Interface
- DATA_W, 32, operand/result width; iteration count equals DATA_W
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ctrl_MULT  in  1  start signed multiply (sampled only in IDLE)
- ctrl_DIV  in  1  start signed divide (sampled only in IDLE)
- data_operandA  in  DATA_W  multiplicand / dividend, captured at start
- data_operandB  in  DATA_W  multiplier / divisor, captured at start
- wb_reg_in  in  5  destination register tag, captured at start
- stall_pipe  out  1  freeze fetch/decode/execute
- data_resultRDY  out  1  one-cycle pulse; result, tag and exception valid
- data_result  out  DATA_W  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero; qualifies exc_code
- exc_code  out  3  rstatus value: 4 = mul, 5 = div, 0 = none
- wb_reg_out  out  5  captured destination tag

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on ctrl_MULT. ctrl_MULT wins if both starts are high.
  - IDLE -> DIV on ctrl_DIV when operandB != 0.
  - IDLE -> DONE on ctrl_DIV when operandB == 0: exception=1, exc_code=5, result=0.
  - MUL/DIV -> DONE after DATA_W iterations; counter runs 0..DATA_W-1.
  - DONE -> IDLE unconditionally.
- Starts arriving outside IDLE are ignored; no queueing.
- MUL: radix-2 Booth over a 2·DATA_W+1 bit accumulator.
  - data_result = low DATA_W bits of the product.
  - Overflow when the upper DATA_W+1 bits of the 2·DATA_W product are not all equal: data_exception=1, exc_code=4. data_result is still the truncated low word.
- DIV: restoring division on magnitudes.
  - Quotient sign = signA XOR signB; truncates toward zero; remainder discarded.
  - Dividend -2^(DATA_W-1), divisor -1: data_exception=1, exc_code=5, data_result=0x80000000.
- data_exception, exc_code and wb_reg_out are meaningful only while data_resultRDY=1. data_result, wb_reg_out, data_exception and exc_code hold their values until the next start.
- stall_pipe = (state is MUL or DIV) OR (state is IDLE AND a start is high). It is low in DONE so the writeback stage captures the result that cycle.
- Reset, including mid-operation: state=IDLE, counter=0, every output 0, no data_resultRDY pulse. The in-flight operation is lost.

## Timing
- Normal op: start sampled at edge E; data_resultRDY high in the cycle after edge E+DATA_W (33 cycles for DATA_W=32); stall_pipe high from the start cycle through E+DATA_W.
- Divide by zero: data_resultRDY high in the cycle after edge E (latency 1); stall_pipe high only in the start cycle.
- Back-to-back: a start in the DONE cycle is ignored. The earliest accepted start is the cycle after data_resultRDY.
- data_resultRDY is exactly one cycle wide.
- All outputs are registered except stall_pipe, which has a combinational path from ctrl_MULT/ctrl_DIV.

## Structure
- Package multdiv_pkg:
  - state enum (IDLE, MUL, DIV, DONE)
  - EXC_NONE=0, EXC_MUL=4, EXC_DIV=5
  - DATA_W default
- Sub-module restoring_div_step: combinational single iteration. Inputs: partial remainder, dividend bit, divisor magnitude. Outputs: next remainder, quotient bit.
- Booth step, counter and FSM stay in the top module.

## Test plan
- mul 7 × -3 -> data_result 0xFFFFFFEB, exception 0, data_resultRDY 33 cycles after start, stall_pipe high 33 cycles, wb_reg_out = wb_reg_in (e.g. 5'd9).
- mul 0x00010000 × 0x00010000 -> data_result 0, exception 1, exc_code 4; mul 0x80000000 × 1 -> 0x80000000, no exception.
- div -7 / 2 -> data_result 0xFFFFFFFD, exception 0; div 100 / -10 -> 0xFFFFFFF6.
- div 5 / 0 -> data_resultRDY the next cycle, result 0, exception 1, exc_code 5; div 0x80000000 / -1 -> result 0x80000000, exc_code 5.
- ctrl_MULT and ctrl_DIV high together with 6, 3 -> multiply performed, result 18. A ctrl_DIV pulse mid-multiply is ignored.
- reset asserted 10 cycles into a div -> all outputs 0 next cycle, no data_resultRDY pulse. A new mul 2 × 2 issued after reset returns 4 at normal latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types, widths and rstatus codes for the multiply/divide sequencer.
package multdiv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned EXC_W  = 3;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  localparam logic [EXC_W-1:0] EXC_NONE = 3'd0;
  localparam logic [EXC_W-1:0] EXC_MUL  = 3'd4;
  localparam logic [EXC_W-1:0] EXC_DIV  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1) unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface multdiv_sequencer_if;
  import multdiv_pkg::*;

  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [TAG_W-1:0]  wb_reg_in;
  logic              stall_pipe;
  logic              data_resultRDY;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic [EXC_W-1:0]  exc_code;
  logic [TAG_W-1:0]  wb_reg_out;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, wb_reg_in,
    input  stall_pipe, data_resultRDY, data_result, data_exception, exc_code, wb_reg_out
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, wb_reg_in,
    output stall_pipe, data_resultRDY, data_result, data_exception, exc_code, wb_reg_out
  );

endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module restoring_div_step #(
  parameter int unsigned WIDTH = multdiv_pkg::DATA_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // A borrow out of the top bit means the divisor did not fit; restore the trial value.
  always_comb begin
    trial   = {rem_i, dividend_bit_i};
    diff    = trial - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) with pipeline stall.
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  multdiv_sequencer_if.slave bus
);

  localparam int unsigned       ACC_W    = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              booth_prev_q, booth_prev_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic              neg_q, neg_d;
  logic              div_ovf_q, div_ovf_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              exc_q, exc_d;
  logic [EXC_W-1:0]  code_q, code_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic [DATA_W:0]     m_ext;
  logic [DATA_W:0]     booth_sum;
  logic [ACC_W-1:0]    booth_acc;
  logic [2*DATA_W-1:0] product;
  logic                mul_ovf;
  logic [DATA_W-1:0]   step_rem;
  logic                step_qbit;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_signed;
  logic                start_c;
  logic                stall_pipe_c;

  // Accumulator is {A[DATA_W:0], Q[DATA_W-1:0]}; the extra A bit keeps A +/- M from overflowing.
  always_comb begin
    m_ext = {opnd_q[DATA_W-1], opnd_q};
    case ({acc_q[0], booth_prev_q})
      2'b10:   booth_sum = acc_q[ACC_W-1:DATA_W] - m_ext;
      2'b01:   booth_sum = acc_q[ACC_W-1:DATA_W] + m_ext;
      default: booth_sum = acc_q[ACC_W-1:DATA_W];
    endcase
    booth_acc = {booth_sum[DATA_W], booth_sum, acc_q[DATA_W-1:1]};
    product   = booth_acc[2*DATA_W-1:0];
    mul_ovf   = !((&product[2*DATA_W-1:DATA_W-1]) || !(|product[2*DATA_W-1:DATA_W-1]));
  end

  // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  restoring_div_step #(.WIDTH(DATA_W)) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[DATA_W-1]),
    .divisor_i      (opnd_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_qbit)
  );

  assign quo_next   = {quo_q[DATA_W-2:0], step_qbit};
  assign quo_signed = neg_q ? (~quo_next + DATA_W'(1)) : quo_next;

  assign start_c      = bus.ctrl_MULT | bus.ctrl_DIV;
  assign stall_pipe_c = (state_q == MUL) || (state_q == DIV) || ((state_q == IDLE) && start_c);

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    booth_prev_d = booth_prev_q;
    opnd_d       = opnd_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    neg_d        = neg_q;
    div_ovf_d    = div_ovf_q;
    rdy_d        = 1'b0;
    result_d     = result_q;
    exc_d        = exc_q;
    code_d       = code_q;
    tag_d        = tag_q;

    case (state_q)
      IDLE: begin
        if (bus.ctrl_MULT) begin
          state_d      = MUL;
          cnt_d        = '0;
          acc_d        = {{(DATA_W+1){1'b0}}, bus.data_operandB};
          booth_prev_d = 1'b0;
          opnd_d       = bus.data_operandA;
          tag_d        = bus.wb_reg_in;
        end else if (bus.ctrl_DIV) begin
          tag_d = bus.wb_reg_in;
          if (bus.data_operandB == '0) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = '0;
            exc_d    = 1'b1;
            code_d   = EXC_DIV;
          end else begin
            state_d   = DIV;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = magnitude(bus.data_operandA);
            opnd_d    = magnitude(bus.data_operandB);
            neg_d     = bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
            div_ovf_d = (bus.data_operandA == INT_MIN) && (&bus.data_operandB);
          end
        end
      end
      MUL: begin
        acc_d        = booth_acc;
        booth_prev_d = acc_q[0];
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = product[DATA_W-1:0];
          exc_d    = mul_ovf;
          code_d   = mul_ovf ? EXC_MUL : EXC_NONE;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = quo_signed;
          exc_d    = div_ovf_q;
          code_d   = div_ovf_q ? EXC_DIV : EXC_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      booth_prev_q <= 1'b0;
      opnd_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      neg_q        <= 1'b0;
      div_ovf_q    <= 1'b0;
      rdy_q        <= 1'b0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      code_q       <= EXC_NONE;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      booth_prev_q <= booth_prev_d;
      opnd_q       <= opnd_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      neg_q        <= neg_d;
      div_ovf_q    <= div_ovf_d;
      rdy_q        <= rdy_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      code_q       <= code_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.stall_pipe     = stall_pipe_c;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.exc_code       = code_q;
  assign bus.wb_reg_out     = tag_q;

endmodule
